// File: rtl/display_scan_controller_pkg.sv
// ---------------------------------------------------------------------------
// display_defs
// Shared definitions for the multiplexed 7-segment scan controller and its
// sequential binary-to-BCD converter.
//   state_t    : controller FSM state encodings
//   DIGITS     : number of displayed decimal digits
//   BCD_W      : width of the packed BCD value {hundreds, tens, units}
//   BIN_W      : width of the binary value to display
//   ANODE_OFF  : active-low anode pattern with every digit dark
// ---------------------------------------------------------------------------
package display_defs;

  localparam int DIGITS = 3;
  localparam int BCD_W  = 12;
  localparam int BIN_W  = 8;

  localparam logic [3:0] ANODE_OFF = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_PENDING = 2'd2
  } state_t;

endpackage

// File: rtl/display_scan_controller_bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq
// Sequential double-dabble converter: one binary bit is shifted into the BCD
// register per clock, after adding 3 to every BCD nibble that is >= 5.
// A conversion takes exactly BIN_W cycles after the start edge.
//   clk      : clock, rising edge
//   reset    : asynchronous active-high reset, clears all state
//   start    : load bin_in and begin a conversion on this edge
//   bin_in   : unsigned binary value to convert
//   done     : high during the cycle whose rising edge performs the final
//              shift; bcd_out is the finished result from that edge onward
//   bcd_out  : {hundreds, tens, units}, stable until the next start
// ---------------------------------------------------------------------------
module bin2bcd_seq
  import display_defs::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [BIN_W-1:0] bin_in,
  output logic             done,
  output logic [BCD_W-1:0] bcd_out
);

  localparam int CNT_W = $clog2(BIN_W + 1);

  logic [BIN_W-1:0] shift_reg;
  logic [BCD_W-1:0] bcd_reg;
  logic [BCD_W-1:0] bcd_adj;
  logic [BCD_W-1:0] bcd_next;
  logic [CNT_W-1:0] bits_left;
  logic             active;

  // Double-dabble correction: any digit that would reach 10 or more after
  // the coming doubling is pre-biased by 3 so the carry lands in the next
  // nibble.
  function automatic logic [BCD_W-1:0] add3_nibbles(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < DIGITS; i++) begin
      if (b[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = b[4*i +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

  always_comb begin
    bcd_adj  = add3_nibbles(bcd_reg);
    bcd_next = {bcd_adj[BCD_W-2:0], shift_reg[BIN_W-1]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_reg <= '0;
      bcd_reg   <= '0;
      bits_left <= '0;
      active    <= 1'b0;
    end else if (start) begin
      shift_reg <= bin_in;
      bcd_reg   <= '0;
      bits_left <= CNT_W'(BIN_W);
      active    <= 1'b1;
    end else if (active) begin
      shift_reg <= {shift_reg[BIN_W-2:0], 1'b0};
      bcd_reg   <= bcd_next;
      bits_left <= bits_left - CNT_W'(1);
      if (bits_left == CNT_W'(1)) begin
        active <= 1'b0;
      end
    end
  end

  // Combinational so the owner can change state on the same edge as the
  // last shift, keeping the conversion at exactly BIN_W cycles.
  assign done    = active && (bits_left == CNT_W'(1));
  assign bcd_out = bcd_reg;

endmodule

// File: rtl/display_scan_controller.sv
// ---------------------------------------------------------------------------
// display_scan_controller
// Accepts an 8-bit binary value, converts it to BCD with a sequential
// double-dabble converter and commits the result to the display only at a
// scan-frame boundary so a frame never shows a mix of old and new digits.
// Scans three digits (digit 3 always dark) with leading-zero blanking.
//   clk          : clock, rising edge
//   reset        : asynchronous active-high reset
//   bin_in       : unsigned value to display
//   bin_valid    : bin_in is valid this cycle
//   bin_ready    : a new value can be accepted (IDLE only)
//   anode_driver : current digit slot, 0 = units
//   BCD_out      : committed value {hundreds, tens, units}
//   an           : active-low anode enables
//   busy         : a value is converting or waiting for its commit
// Parameter REFRESH_DIV: clock cycles per digit slot (2..2^20).
// ---------------------------------------------------------------------------
module display_scan_controller
  import display_defs::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [BIN_W-1:0] bin_in,
  input  logic             bin_valid,
  output logic             bin_ready,
  output logic [1:0]       anode_driver,
  output logic [BCD_W-1:0] BCD_out,
  output logic [3:0]       an,
  output logic             busy
);

  localparam int             PRE_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);

  logic [PRE_W-1:0] pre_cnt;
  logic             tick;
  logic             frame;

  state_t           state;
  state_t           state_next;
  logic             conv_start;
  logic             conv_done;
  logic [BCD_W-1:0] conv_bcd;
  logic             commit;

  logic [3:0]       hundreds;
  logic [3:0]       tens;
  logic             blank_d2;
  logic             blank_d1;

  // Prescaler and digit-slot counter
  assign tick  = (pre_cnt == PRE_LAST);
  assign frame = tick && (anode_driver == 2'd3);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_cnt      <= '0;
      anode_driver <= '0;
    end else if (tick) begin
      pre_cnt      <= '0;
      anode_driver <= anode_driver + 2'd1;
    end else begin
      pre_cnt      <= pre_cnt + PRE_W'(1);
    end
  end

  // Conversion / commit FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A conversion finishing on a frame-boundary edge lands in PENDING on that
  // same edge; the commit therefore naturally waits for the next boundary.
  always_comb begin
    state_next = state;
    conv_start = 1'b0;
    commit     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bin_valid) begin
          conv_start = 1'b1;
          state_next = ST_CONVERT;
        end
      end
      ST_CONVERT: begin
        if (conv_done) begin
          state_next = ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (frame) begin
          commit     = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign bin_ready = (state == ST_IDLE);
  assign busy      = (state == ST_CONVERT) || (state == ST_PENDING);

  bin2bcd_seq u_bin2bcd (
    .clk     (clk),
    .reset   (reset),
    .start   (conv_start),
    .bin_in  (bin_in),
    .done    (conv_done),
    .bcd_out (conv_bcd)
  );

  // Committed display value
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      BCD_out <= '0;
    end else if (commit) begin
      BCD_out <= conv_bcd;
    end
  end

  // Anode decode with leading-zero blanking; units digit is always lit.
  assign hundreds = BCD_out[11:8];
  assign tens     = BCD_out[7:4];
  assign blank_d2 = (hundreds == 4'd0);
  assign blank_d1 = (hundreds == 4'd0) && (tens == 4'd0);

  always_comb begin
    an = ANODE_OFF;
    case (anode_driver)
      2'd0: an[0] = 1'b0;
      2'd1: an[1] = blank_d1;
      2'd2: an[2] = blank_d2;
      default: an = ANODE_OFF;
    endcase
  end

endmodule
